// File: rtl/motors_cmd_dispatcher.sv
// Motors-control command dispatcher: queues motion commands in a small FIFO and issues
// them one at a time to the motors controller over the trigger/rdy/done handshake.
module motors_cmd_dispatcher #(
    parameter int PULSE_NUM_X_BITS = 16,
    parameter int PULSE_NUM_Y_BITS = 16,
    parameter int SERVO_POS_BITS   = 1,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk_en,
    input  logic                        in_valid,
    input  logic [PULSE_NUM_X_BITS-1:0] in_pulse_num_x,
    input  logic [PULSE_NUM_Y_BITS-1:0] in_pulse_num_y,
    input  logic [SERVO_POS_BITS-1:0]   in_servo_pos,
    output logic                        in_rdy,
    input  logic                        flush,
    input  logic                        motors_rdy,
    input  logic                        motors_done,
    output logic                        motors_trigger,
    output logic [PULSE_NUM_X_BITS-1:0] motors_pulse_num_x,
    output logic [PULSE_NUM_Y_BITS-1:0] motors_pulse_num_y,
    output logic [SERVO_POS_BITS-1:0]   motors_servo_pos,
    output logic                        busy,
    output logic [15:0]                 cmd_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] L_DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [PULSE_NUM_X_BITS-1:0] r_mem_x [FIFO_DEPTH];
    logic [PULSE_NUM_Y_BITS-1:0] r_mem_y [FIFO_DEPTH];
    logic [SERVO_POS_BITS-1:0]   r_mem_s [FIFO_DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [PULSE_NUM_X_BITS-1:0] r_op_x;
    logic [PULSE_NUM_Y_BITS-1:0] r_op_y;
    logic [SERVO_POS_BITS-1:0]   r_op_s;
    logic [15:0]                 r_cmd_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_complete;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == L_DEPTH);

    // flush wins over a same-cycle push and blocks the launch of a new command
    assign w_push     = clk_en & in_valid & ~w_full & ~flush;
    assign w_pop      = clk_en & (r_state == S_IDLE) & ~w_empty & motors_rdy & ~flush;
    assign w_complete = clk_en & (r_state == S_WAIT_DONE) & motors_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else if (clk_en) begin
            r_state <= w_next_state;
        end
    end

    // done is not looked at in ISSUE: it may still be high from the previous command
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && motors_rdy && !flush) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (motors_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_x[r_wr_ptr] <= in_pulse_num_x;
            r_mem_y[r_wr_ptr] <= in_pulse_num_y;
            r_mem_s[r_wr_ptr] <= in_servo_pos;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clk_en) begin
            if (flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // operands persist until the next launch; never cleared between commands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op_x <= '0;
            r_op_y <= '0;
            r_op_s <= '0;
        end else if (w_pop) begin
            r_op_x <= r_mem_x[r_rd_ptr];
            r_op_y <= r_mem_y[r_rd_ptr];
            r_op_s <= r_mem_s[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_count <= '0;
        end else if (w_complete) begin
            r_cmd_count <= r_cmd_count + 16'd1;
        end
    end

    assign in_rdy             = ~w_full;
    assign motors_trigger     = (r_state == S_ISSUE);
    assign motors_pulse_num_x = r_op_x;
    assign motors_pulse_num_y = r_op_y;
    assign motors_servo_pos   = r_op_s;
    assign busy               = (r_state != S_IDLE) | ~w_empty;
    assign cmd_count          = r_cmd_count;

endmodule

// File: doc/motors_cmd_dispatcher.md
# motors_cmd_dispatcher

Initiator side of the motors-control command interface: accepts motion commands (signed X/Y pulse counts plus servo position) from the upstream command source into a small FIFO. It issues them one at a time to the motors controller with the trigger/rdy/done handshake. It holds each command's operands stable until the controller reports completion, and counts completed commands. It sits between the command parser and the motors controller.

## Interface
- PULSE_NUM_X_BITS, 16: width of signed X pulse count (two's complement; sign = direction).
- PULSE_NUM_Y_BITS, 16: width of signed Y pulse count.
- SERVO_POS_BITS, 1: width of servo position field.
- FIFO_DEPTH, 4: command FIFO depth; power of two, ≥2.
- clk  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted); deassertion synchronous to clk by upstream.
- clk_en  in  1  module enabling clock; every state, FIFO and counter update is qualified by clk_en=1.
- in_valid  in  1  upstream command valid.
- in_pulse_num_x  in  PULSE_NUM_X_BITS  command X pulse count.
- in_pulse_num_y  in  PULSE_NUM_Y_BITS  command Y pulse count.
- in_servo_pos  in  SERVO_POS_BITS  command servo position.
- in_rdy  out  1  FIFO not full (combinational from occupancy).
- flush  in  1  discard all queued (not in-flight) commands.
- motors_rdy  in  1  controller ready for a trigger.
- motors_done  in  1  controller finished the triggered command (level).
- motors_trigger  out  1  one-enabled-cycle start strobe.
- motors_pulse_num_x  out  PULSE_NUM_X_BITS  operand to controller.
- motors_pulse_num_y  out  PULSE_NUM_Y_BITS  operand to controller.
- motors_servo_pos  out  SERVO_POS_BITS  operand to controller.
- busy  out  1  command in flight or FIFO non-empty.
- cmd_count  out  16  completed-command counter, wraps 0xFFFF→0.

## Operation
- FIFO: push when clk_en & in_valid & in_rdy. Pop only on IDLE→ISSUE. Push and pop in the same enabled cycle leave occupancy unchanged. No fall-through: a command pushed at edge N is poppable no earlier than edge N+1.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE: if FIFO non-empty & motors_rdy & !flush → ISSUE. On that edge, latch the FIFO head into the motors_* operand registers and pop.
- ISSUE: motors_trigger=1 (decoded from state). Next enabled edge → WAIT_DONE unconditionally. motors_done is ignored in ISSUE, because it may be stale from the previous command.
- WAIT_DONE: on first enabled edge with motors_done=1 → IDLE and cmd_count+1. Otherwise stay.
- Operands stay constant from the ISSUE entry until the next IDLE→ISSUE latch; they are never cleared between commands.
- flush (sampled when clk_en=1): empties the FIFO (occupancy=0). In that cycle, flush has priority over a simultaneous push or pop: the push is dropped and the IDLE→ISSUE transition is blocked. An in-flight command (ISSUE/WAIT_DONE) completes normally and is counted.
- busy = (state≠IDLE) | FIFO non-empty.
- clk_en=0: all registers hold; motors_trigger stays high if state=ISSUE (a strobe lasts exactly one enabled cycle).

## Timing
- Reset values: state IDLE, FIFO empty, in_rdy=1, motors_trigger=0, motors_pulse_num_x/y=0, motors_servo_pos=0, busy=0, cmd_count=0. Reset assertion mid-operation clears immediately (asynchronous), including dropping motors_trigger.
- Latency with clk_en held high and motors_rdy=1: push at edge N → state ISSUE after edge N+1 (trigger high in cycle N+1..N+2) → WAIT_DONE after edge N+2.
- Back-to-back: done sampled at edge M → IDLE. If the FIFO is non-empty and motors_rdy=1, → ISSUE at edge M+1. Minimum 3 enabled cycles per command plus the controller's time.
- Full: occupancy=FIFO_DEPTH → in_rdy=0. in_rdy returns to 1 in the cycle after the popping edge.
- motors_rdy low in IDLE: wait indefinitely, with no timeout.

## Test plan
- Reset: drive reset=0 mid-WAIT_DONE with 2 queued commands → all outputs at reset values immediately; after release, in_rdy=1, busy=0, cmd_count=0.
- Single command: push (X=100, Y=-50, servo=1) with clk_en=1, motors_rdy=1 → trigger high for exactly one cycle, 2 edges after the push. Operands are 100 / 0xFFCE / 1 and stay stable. Done asserted 10 cycles later → cmd_count=1, busy=0.
- Fill/backpressure: hold motors_rdy=0 and push 5 commands → in_rdy=0 after 4. Then release motors_rdy with auto-done → 4 triggers, operands in push order, cmd_count=4.
- Stale done: hold motors_done=1 continuously → each command still spends exactly one cycle in ISSUE and completes on the following enabled edge; never a double count.
- Flush: 3 queued plus 1 in flight, assert flush for 1 cycle with a simultaneous push → the push is dropped, the FIFO is empty, the in-flight command completes, and cmd_count increments by 1 only.
- clk_en: toggle clk_en at 1-in-4 → same trigger/operand sequence as full rate. The trigger spans exactly one enabled cycle, and no update occurs on disabled cycles.
